// File: rtl/mem_bus_arbiter.sv
// Two-to-one arbiter putting the fetch and data ports onto one shared memory bus.
// Fixed data-over-fetch priority by default; define ARB_RR_EN for round-robin on ties.
module mem_bus_arbiter #(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [AW-1:0]     i_addr,
    input  logic [2:0]        i_size,
    output logic              i_addr_ok,
    output logic              i_data_ok,
    output logic [31:0]       i_data,
    input  logic              d_valid,
    input  logic [AW-1:0]     d_addr,
    input  logic [2:0]        d_size,
    input  logic [DW/8-1:0]   d_strobe,
    input  logic [DW-1:0]     d_wdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,
    output logic [DW-1:0]     d_rdata,
    output logic              c_valid,
    output logic [AW-1:0]     c_addr,
    output logic [2:0]        c_size,
    output logic [DW/8-1:0]   c_strobe,
    output logic [DW-1:0]     c_wdata,
    input  logic              c_data_ok,
    input  logic [DW-1:0]     c_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [AW-1:0]       r_addr;
    logic [2:0]          r_size;
    logic [DW/8-1:0]     r_strobe;
    logic [DW-1:0]       r_wdata;
    logic                w_idle;
    logic                w_pick_d;
    logic                w_pick_i;
    logic                w_gnt_d;
    logic                w_gnt_i;
    logic [31:0]         w_word;

`ifdef ARB_RR_EN
    logic                r_last_d;

    // Tie goes to whoever did not win last; a lone request always wins.
    always_comb begin
        w_pick_d = d_valid && !(i_valid && r_last_d);
        w_pick_i = i_valid && !w_pick_d;
    end

    // Remember the most recent winner on every grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_d <= 1'b1;
        end else if (w_gnt_d) begin
            r_last_d <= 1'b1;
        end else if (w_gnt_i) begin
            r_last_d <= 1'b0;
        end
    end
`else
    // Fixed priority: data beats fetch.
    always_comb begin
        w_pick_d = d_valid;
        w_pick_i = i_valid && !d_valid;
    end
`endif

    // Grants only happen from IDLE and never while reset is held.
    always_comb begin
        w_idle  = (r_state == IDLE) && !reset;
        w_gnt_d = w_idle && w_pick_d;
        w_gnt_i = w_idle && w_pick_i;
        w_word  = r_addr[2] ? c_rdata[63:32] : c_rdata[31:0];
    end

    // State register and request latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_size   <= '0;
            r_strobe <= '0;
            r_wdata  <= '0;
        end else begin
            r_state <= w_next;
            if (w_gnt_d) begin
                r_addr   <= d_addr;
                r_size   <= d_size;
                r_strobe <= d_strobe;
                r_wdata  <= d_wdata;
            end else if (w_gnt_i) begin
                r_addr   <= i_addr;
                r_size   <= i_size;
                r_strobe <= '0;
                r_wdata  <= '0;
            end
        end
    end

    // Next-state logic and handshake/bus outputs.
    always_comb begin
        w_next    = r_state;
        i_addr_ok = w_gnt_i;
        d_addr_ok = w_gnt_d;
        i_data_ok = 1'b0;
        d_data_ok = 1'b0;
        i_data    = '0;
        d_rdata   = '0;
        c_valid   = 1'b0;
        c_addr    = r_addr;
        c_size    = r_size;
        c_strobe  = r_strobe;
        c_wdata   = r_wdata;
        unique case (r_state)
            IDLE: begin
                if (w_gnt_d) begin
                    w_next = OWN_D;
                end else if (w_gnt_i) begin
                    w_next = OWN_I;
                end
            end
            OWN_I: begin
                c_valid = !reset;
                if (c_data_ok) begin
                    w_next = IDLE;
                end
                if (c_data_ok && !reset) begin
                    i_data_ok = 1'b1;
                    i_data    = w_word;
                end
            end
            OWN_D: begin
                c_valid = !reset;
                if (c_data_ok) begin
                    w_next = IDLE;
                end
                if (c_data_ok && !reset) begin
                    d_data_ok = 1'b1;
                    d_rdata   = c_rdata;
                end
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-to-one arbiter placing the core's instruction-fetch port and data-access port onto a single shared memory bus. It sits between `core` and the memory/cache subsystem. It locks one requester at a time, registers that requester's request, and routes the shared response back to the owner only. The shared bus has one outstanding transaction at a time.

## Interface

Parameters:
- `AW`, default 64: address width.
- `DW`, default 64: data width; strobe width is `DW/8`.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `i_valid`, `i_addr`, `i_size`, in, 1/AW/3: fetch request. `i_size` uses the MSIZE encoding; fetch is always a read.
- `i_addr_ok`, `i_data_ok`, out, 1/1: fetch handshake.
- `i_data`, out, 32: fetch data. It is the 32-bit word at `i_addr`, taken from `c_data[31:0]` or `c_data[63:32]` selected by `i_addr[2]`.
- `d_valid`, `d_addr`, `d_size`, `d_strobe`, `d_wdata`, in, 1/AW/3/DW/8/DW: data request. `d_strobe` = 0 means a read.
- `d_addr_ok`, `d_data_ok`, out, 1/1: data handshake.
- `d_rdata`, out, DW: data read result.
- `c_valid`, `c_addr`, `c_size`, `c_strobe`, `c_wdata`, out, 1/AW/3/DW/8/DW: shared bus request.
- `c_data_ok`, in, 1: shared bus completion pulse.
- `c_rdata`, in, DW: shared bus read data.

## Operation

- State machine with three states: IDLE, OWN_I, OWN_D.
- IDLE:
  - `c_valid` = 0.
  - If `d_valid` = 1, go to OWN_D. Data has priority by default.
  - Else if `i_valid` = 1, go to OWN_I.
  - On the transition, register the winner's addr, size, strobe and wdata into the request latch. For a fetch, strobe is forced to 0 and wdata to 0.
  - In the same cycle, pulse the winner's `*_addr_ok` = 1.
- OWN_x:
  - `c_valid` = 1, and the `c_*` fields are driven from the latch only, never from the live inputs.
  - Wait for `c_data_ok`.
  - On `c_data_ok` = 1: pulse the owner's `*_data_ok` = 1 for one cycle, drive `i_data`/`d_rdata` from `c_rdata` in that cycle, and go to IDLE.
- Non-owner handshake outputs stay at 0 throughout.
- `i_data` and `d_rdata` are don't-care outside the `data_ok` cycle. They are driven 0 for determinism.
- Owner drops `*_valid` mid-transaction: the shared transaction still completes from the latch, and `*_data_ok` still pulses. The requester ignores it.
- Loser holds `*_valid`: it waits with no handshake. It is evaluated in the next IDLE cycle.
- `c_data_ok` asserted while in IDLE: ignored, and no requester sees `data_ok`.

## Timing

- Reset values: state = IDLE, request latch = 0, `c_valid` = 0, all `*_addr_ok`/`*_data_ok` = 0, `i_data` = 0, `d_rdata` = 0.
- Reset asserted mid-transaction:
  - The arbiter abandons the transaction.
  - The next cycle is IDLE with `c_valid` = 0.
  - No `data_ok` is emitted.
- Cycle sequence for a transaction:
  - Cycle T: request sampled in IDLE, and `addr_ok` pulses.
  - Cycle T+1: first cycle with `c_valid` = 1.
  - Cycle T+1+L: `c_data_ok` arrives, and the owner's `data_ok` is combinational in that same cycle.
  - Cycle T+2+L: IDLE.
- Latency: request-to-`data_ok` = L + 1 cycles, where L ≥ 0 is the bus latency counted from the first `c_valid` cycle.
- Back-to-back: one mandatory IDLE cycle between transactions. Minimum period = L + 2 cycles.
- `c_valid` is held high continuously from OWN entry to `c_data_ok`. The `c_*` fields are stable over that whole interval.

## Configuration

- `ARB_RR_EN` undefined: fixed priority, data over fetch.
- `ARB_RR_EN` defined: a 1-bit `last_grant` register (reset value: data) records the last winner.
  - When both requests are valid in IDLE, the requester not granted last wins.
  - A single valid request always wins regardless of `last_grant`.
  - `last_grant` updates on every IDLE→OWN transition.

## Test plan

- Fetch only. `i_valid` = 1, `i_addr` = 0x8000_0004, bus returns 0x1111_2222_3333_4444 with L = 2.
  - `i_addr_ok` at T, `c_valid` at T+1..T+3, `i_data_ok` at T+3.
  - `i_data` = 0x1111_2222 (upper word, since `i_addr[2]` = 1).
  - `d_*` handshake outputs stay 0.
- Data store. `d_addr` = 0x10, `d_strobe` = 0xF0, `d_wdata` = 0xAABB_CCDD_0000_0000.
  - `c_strobe` = 0xF0 and `c_wdata` match, held stable while `c_valid` = 1.
  - `d_data_ok` pulses once.
- Simultaneous `i_valid` and `d_valid` for two consecutive transactions:
  - Without `ARB_RR_EN`: D then D.
  - With `ARB_RR_EN`: I (since `last_grant` resets to data), then D.
- Owner drops `d_valid` at T+1 and changes `d_addr` to 0x0.
  - `c_addr` stays at the latched value.
  - `d_data_ok` still pulses on completion, then IDLE.
- Reset asserted during OWN_I with `c_data_ok` pending.
  - Next cycle: IDLE, `c_valid` = 0.
  - A later stray `c_data_ok` produces no `i_data_ok`.
- Stray `c_data_ok` = 1 in IDLE with no requests: all handshake outputs remain 0, and the state stays IDLE.
